// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-code signal bundle
// master is the scanner side; slave is the keypad/lock side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (input row_n, output col_n, key_code, key_valid);
  modport slave  (output row_n, input col_n, key_code, key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column strobe, single-key debounce and decode
// One column is driven low per slot; rows are judged only on the slot-end tick.
module keypad_scanner #(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input logic              MAX10_CLK1_50,
  input logic              reset,
  keypad_scanner_if.master kp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DEBOUNCE_SAMPLES);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  logic [3:0]    row_meta, row_sync;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    state;
  logic [3:0]    col_n_r;
  logic [1:0]    key_row;
  logic [NW-1:0] match_cnt, rel_cnt;
  logic [3:0]    key_code_r;
  logic          key_valid_r;

  logic       tick;
  logic [3:0] row_low;
  logic       one_low;
  logic [1:0] low_idx;
  logic [1:0] col_idx;
  logic [3:0] col_adv;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hF;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick    = (slot_cnt == SLOT_LAST);
  assign row_low = ~row_sync;
  assign one_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign col_adv = {col_n_r[2:0], col_n_r[3]};

  always_comb begin
    low_idx = 2'd0;
    case (row_low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_n_r)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      slot_cnt    <= '0;
      state       <= SCAN;
      col_n_r     <= 4'b1110;
      key_row     <= 2'd0;
      match_cnt   <= '0;
      rel_cnt     <= '0;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
    end else begin
      row_meta <= kp.row_n;
      row_sync <= row_meta;
      slot_cnt <= tick ? '0 : slot_cnt + CW'(1);
      case (state)
        SCAN: if (tick) begin
          if (one_low) begin
            key_row    <= low_idx;
            key_code_r <= key_map(low_idx, col_idx);
            match_cnt  <= NW'(1);
            state      <= DEBOUNCE;
          end else begin
            col_n_r <= col_adv;
          end
        end
        DEBOUNCE: if (tick) begin
          if (one_low && (low_idx == key_row)) begin
            if (match_cnt + NW'(1) == N_LAST) begin
              state       <= HELD;
              key_valid_r <= 1'b1;
              match_cnt   <= '0;
              rel_cnt     <= '0;
            end else begin
              match_cnt <= match_cnt + NW'(1);
            end
          end else begin
            // column is still frozen on the aborted key, so rotating moves to c+1
            state     <= SCAN;
            match_cnt <= '0;
            col_n_r   <= col_adv;
          end
        end
        HELD: if (tick) begin
          if (row_sync[key_row]) begin
            if (rel_cnt + NW'(1) == N_LAST) begin
              state       <= SCAN;
              key_valid_r <= 1'b0;
              rel_cnt     <= '0;
              col_n_r     <= col_adv;
            end else begin
              rel_cnt <= rel_cnt + NW'(1);
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: begin
          state       <= SCAN;
          key_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign kp.col_n     = col_n_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized keypad presses checked against a keypad/debounce model
// A physical keypad model drives row_n from the DUT's column strobes.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] pressed;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SAMPLES(DB)) dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .kp           (kif)
  );

  always_comb begin
    kif.row_n = 4'hF;
    for (int r = 0; r < 4; r++) kif.row_n[r] = ~|(pressed[r*4 +: 4] & ~kif.col_n);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: keypad as a set of pressed keys, 2-edge row delay, per-tick rules.
  string km = "123A456B789C*0#D";
  int m_cyc = 0, m_col = 0, m_mode = 0, m_r = 0, m_c = 0, m_streak = 0, m_rel = 0;
  logic [3:0] m_code = 4'h0;
  bit m_valid = 1'b0;
  logic [3:0] pipe1 = 4'hF, pipe2 = 4'hF;

  function automatic logic [3:0] code_of(input int r, input int c);
    byte ch;
    ch = km[r*4 + c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'hF;
    return 4'hE;
  endfunction

  function automatic logic [3:0] rows_for(input logic [15:0] p, input int col);
    logic [3:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = ~p[r*4 + col];
    return rows;
  endfunction

  task automatic model_edge();
    logic [3:0] now, synced;
    int nlow, idx;
    bit tick;
    if (reset) begin
      m_cyc = 0; m_col = 0; m_mode = 0; m_streak = 0; m_rel = 0;
      m_code = 4'h0; m_valid = 1'b0; pipe1 = 4'hF; pipe2 = 4'hF;
      return;
    end
    now = rows_for(pressed, m_col);
    synced = pipe2;
    pipe2 = pipe1;
    pipe1 = now;
    tick = (m_cyc == SD - 1);
    m_cyc = (m_cyc + 1) % SD;
    if (!tick) return;
    nlow = 0; idx = 0;
    for (int r = 0; r < 4; r++) if (!synced[r]) begin nlow++; idx = r; end
    if (m_mode == 0) begin
      if (nlow == 1) begin
        m_r = idx; m_c = m_col; m_code = code_of(idx, m_col); m_streak = 1; m_mode = 1;
      end else m_col = (m_col + 1) % 4;
    end else if (m_mode == 1) begin
      if (nlow == 1 && idx == m_r) begin
        m_streak++;
        if (m_streak == DB) begin m_mode = 2; m_valid = 1'b1; m_rel = 0; end
      end else begin
        m_mode = 0; m_col = (m_c + 1) % 4;
      end
    end else begin
      if (synced[m_r]) begin
        m_rel++;
        if (m_rel == DB) begin m_mode = 0; m_valid = 1'b0; m_col = (m_c + 1) % 4; end
      end else m_rel = 0;
    end
  endtask

  task automatic step();
    logic [3:0] exp_col;
    @(posedge clk);
    #1;
    model_edge();
    exp_col = ~(4'b0001 << m_col);
    chk("col_n", kif.col_n, exp_col);
    chk("key_code", kif.key_code, m_code);
    chk("key_valid", kif.key_valid, m_valid);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int kind, k, k2;
    reset = 1'b1;
    pressed = 16'h0;
    run(3);
    chk("rst_col", kif.col_n, 8'h0E);
    chk("rst_code", kif.key_code, 8'h00);
    chk("rst_valid", kif.key_valid, 8'h00);
    reset = 1'b0;
    run(3);
    chk("scan_col0", kif.col_n, 8'h0E);
    run(1);
    chk("scan_col1", kif.col_n, 8'h0D);
    run(16);

    pressed = 16'h1 << (1*4 + 1);
    run(40);
    chk("k5_code", kif.key_code, 8'h05);
    chk("k5_valid", kif.key_valid, 8'h01);
    chk("k5_col", kif.col_n, 8'h0D);
    pressed = 16'h0;
    run(30);
    chk("k5_rel_valid", kif.key_valid, 8'h00);
    chk("k5_rel_code", kif.key_code, 8'h05);

    pressed = 16'h1 << (3*4 + 2);
    run(40);
    chk("khash_valid", kif.key_valid, 8'h01);
    pressed = 16'h0;
    run(30);
    chk("khash_code", kif.key_code, 8'h0E);
    chk("khash_rel", kif.key_valid, 8'h00);

    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      run(SD);
    end
    pressed = 16'h0001;
    run(40);
    chk("k1_code", kif.key_code, 8'h01);
    chk("k1_valid", kif.key_valid, 8'h01);
    pressed = 16'h0;
    run(30);

    pressed = 16'h1 << 12;
    run(40);
    chk("kstar_code", kif.key_code, 8'h0F);
    pressed = 16'h0;
    run(30);

    pressed = (16'h1 << 3) | (16'h1 << 11);
    run(60);
    chk("dual_valid", kif.key_valid, 8'h00);
    chk("dual_code", kif.key_code, 8'h0F);
    pressed = 16'h0;
    run(10);

    pressed = 16'h1 << (2*4 + 1);
    run(40);
    chk("k8_valid", kif.key_valid, 8'h01);
    reset = 1'b1;
    step();
    chk("hrst_valid", kif.key_valid, 8'h00);
    chk("hrst_code", kif.key_code, 8'h00);
    chk("hrst_col", kif.col_n, 8'h0E);
    reset = 1'b0;
    run(40);
    chk("k8_redetect", kif.key_valid, 8'h01);
    chk("k8_code", kif.key_code, 8'h08);
    pressed = 16'h0;
    run(30);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      k = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      if (kind <= 1) begin
        pressed = 16'h0;
        run($urandom_range(1, 20));
      end else if (kind <= 6) begin
        repeat ($urandom_range(0, 12)) begin
          pressed = $urandom_range(0, 1) ? (16'h1 << k) : 16'h0;
          step();
        end
        pressed = 16'h1 << k;
        run($urandom_range(1, 50));
        repeat ($urandom_range(0, 8)) begin
          pressed = $urandom_range(0, 1) ? (16'h1 << k) : 16'h0;
          step();
        end
        pressed = 16'h0;
        run($urandom_range(1, 30));
      end else if (kind <= 8) begin
        pressed = (16'h1 << k) | (16'h1 << k2);
        run($urandom_range(5, 50));
        pressed = 16'h0;
        run($urandom_range(1, 30));
      end else begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
        run($urandom_range(1, 10));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
